muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage, directly downstream of the register file. It consumes the two register read values, which are presented as operand_a/operand_b, plus funct3 for the M-extension op. It produces a 32-bit result for the writeback path, which becomes the register file's writedata. The unit uses a start/busy/done handshake so the core controller can hold its state machine while the unit iterates.

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_signed_s, b_signed_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, fix_result_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Operand signedness decoded from the requested op.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'd2:                   begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            default:                begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end

    // Datapath step and sign-corrected final result.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_q, lo_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_q};
        prod_s      = {hi_q, lo_q};
        prod_fix_s  = (sign_a_q ^ sign_b_q) ? -prod_s : prod_s;
        // A zero divisor bypasses sign correction entirely.
        if (b_zero_q) begin
            quo_fix_s = {WIDTH{1'b1}};
            rem_fix_s = raw_a_q;
        end else begin
            quo_fix_s = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
            rem_fix_s = sign_a_q ? -hi_q : hi_q;
        end
        case (op_q)
            3'd0:             fix_result_s = prod_fix_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: fix_result_s = prod_fix_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       fix_result_s = quo_fix_s;
            3'd6, 3'd7:       fix_result_s = rem_fix_s;
            default:          fix_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and register-update logic for the control FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        raw_a_d  = raw_a_q;
        mag_d    = mag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = {CNT_W{1'b0}};
                    op_d     = funct3;
                    sign_a_d = a_signed_s & operand_a[WIDTH-1];
                    sign_b_d = b_signed_s & operand_b[WIDTH-1];
                    b_zero_d = (operand_b == {WIDTH{1'b0}});
                    raw_a_d  = operand_a;
                    hi_d     = {WIDTH{1'b0}};
                    // lo holds the operand consumed bit by bit; mag is the one added/subtracted.
                    if (funct3[2]) begin
                        lo_d  = magnitude(operand_a, a_signed_s);
                        mag_d = magnitude(operand_b, b_signed_s);
                    end else begin
                        lo_d  = magnitude(operand_b, b_signed_s);
                        mag_d = magnitude(operand_a, a_signed_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    if (!div_diff_s[WIDTH]) begin
                        hi_d = div_diff_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum_s[WIDTH:1];
                    lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d  = S_DONE;
                result_d = fix_result_s;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FIX);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 3'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            raw_a_q  <= {WIDTH{1'b0}};
            mag_q    <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            raw_a_q  <= raw_a_d;
            mag_q    <= mag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of hand-computed M-extension vectors plus
// sequences for ignored starts and mid-operation reset.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE and check latency, result and return to idle.
    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        @(negedge clk);
        funct3 = f3; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct3 = ~f3; operand_a = ~a; operand_b = b ^ 32'h5A5A_A5A5;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
        check({name, " latency"}, 32'(n), 32'd33);
        check({name, " result"}, result, exp);
        @(posedge clk);
        #1;
        check({name, " idle after done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int done_at;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; start = 1'b0; funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
        vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        vecs[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // MUL 3x4 with starts at cycle 5 and in the done cycle; both must be dropped.
        @(negedge clk);
        funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            operand_a = 32'd100; operand_b = 32'd100;
            start = (k == 4) || (k == 33 && done);
        end
        check("ignored start done count", 32'(done_cnt), 32'd1);
        check("ignored start latency", 32'(done_at), 32'd33);
        check("ignored start result", result, 32'd12);
        check("ignored start busy", {31'd0, busy}, 32'd0);

        // Reset ten cycles into a DIV must clear everything immediately.
        @(negedge clk);
        funct3 = 3'd4; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid-op busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_op("divu after reset", 3'd5, 32'd9, 32'd3, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
